// File: rtl/cmp_bitscan_seq.sv
// Multi-cycle bit-scan branch-condition sequencer: popcount / highest-set-bit
// over 32-bit operands, STEP bits per cycle, fixed latency, stall while busy.
module cmp_bitscan_seq #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [1:0]  mode,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        cond,
  output logic [5:0]  result
);

  localparam int NCHUNK = 32 / STEP;
  localparam int CW     = $clog2(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  localparam logic [1:0] M_CNT_EQ  = 2'b00;
  localparam logic [1:0] M_HIGH_EQ = 2'b01;
  localparam logic [1:0] M_CNT_GE  = 2'b10;

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [1:0]    mode_q, mode_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [5:0]    cnta_q, cnta_d, cntb_q, cntb_d, high_q, high_d;
  logic          found_q, found_d;
  logic [5:0]    result_q, result_d;
  logic          cond_q, cond_d;

  // Per-cycle slice scan: contribution of the current chunk folded into
  // the running accumulators.
  logic [5:0]      base;
  logic [STEP-1:0] sa, sb;
  logic [5:0]      cnta_n, cntb_n, high_n;
  logic            found_n;

  always_comb begin
    base    = 6'(chunk_q) * 6'(STEP);
    sa      = a_q[base +: STEP];
    sb      = b_q[base +: STEP];
    cnta_n  = cnta_q;
    cntb_n  = cntb_q;
    high_n  = high_q;
    found_n = found_q;
    for (int i = 0; i < STEP; i++) begin
      cnta_n = cnta_n + 6'(sa[i]);
      cntb_n = cntb_n + 6'(sb[i]);
      // Low-to-high scan: the last set bit seen is the highest.
      if (sa[i]) begin
        high_n  = base + 6'(i);
        found_n = 1'b1;
      end
    end
  end

  // Final condition, evaluated on the last chunk so it lands with DONE.
  logic [5:0] fin_res;
  logic       fin_cond;

  always_comb begin
    fin_res  = 6'd0;
    fin_cond = 1'b0;
    case (mode_q)
      M_CNT_EQ: begin
        fin_res  = cnta_n;
        fin_cond = (cnta_n == b_q[5:0]);
      end
      M_HIGH_EQ: begin
        fin_res  = found_n ? high_n : 6'd63;
        fin_cond = (fin_res == b_q[5:0]);
      end
      M_CNT_GE: begin
        fin_res  = cnta_n;
        fin_cond = (cnta_n >= cntb_n);
      end
      default: begin
        fin_res  = 6'd0;
        fin_cond = 1'b0;
      end
    endcase
  end

  logic accept_ok, accept;
  // Flush outranks start, so a flushed cycle never counts as an accept.
  assign accept_ok = (state_q != S_RUN) && !flush;
  assign accept    = start && accept_ok;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    chunk_d  = chunk_q;
    cnta_d   = cnta_q;
    cntb_d   = cntb_q;
    high_d   = high_q;
    found_d  = found_q;
    result_d = result_q;
    cond_d   = cond_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d  = S_RUN;
          a_d      = srcA;
          b_d      = srcB;
          mode_d   = mode;
          chunk_d  = '0;
          cnta_d   = 6'd0;
          cntb_d   = 6'd0;
          high_d   = 6'd0;
          found_d  = 1'b0;
          result_d = 6'd0;
          cond_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d  = S_IDLE;
          chunk_d  = '0;
          cnta_d   = 6'd0;
          cntb_d   = 6'd0;
          high_d   = 6'd0;
          found_d  = 1'b0;
          result_d = 6'd0;
          cond_d   = 1'b0;
        end else begin
          cnta_d  = cnta_n;
          cntb_d  = cntb_n;
          high_d  = high_n;
          found_d = found_n;
          if (chunk_q == LAST) begin
            state_d  = S_DONE;
            chunk_d  = '0;
            result_d = fin_res;
            cond_d   = fin_cond;
          end else begin
            chunk_d = chunk_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 2'b00;
      chunk_q  <= '0;
      cnta_q   <= 6'd0;
      cntb_q   <= 6'd0;
      high_q   <= 6'd0;
      found_q  <= 1'b0;
      result_q <= 6'd0;
      cond_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      chunk_q  <= chunk_d;
      cnta_q   <= cnta_d;
      cntb_q   <= cntb_d;
      high_q   <= high_d;
      found_q  <= found_d;
      result_q <= result_d;
      cond_q   <= cond_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign stall  = busy | accept;
  assign result = result_q;
  assign cond   = cond_q;

endmodule

// File: doc/cmp_bitscan_seq.md
Name: cmp_bitscan_seq

Overview:
Multi-cycle sequencer for the bit-scan branch conditions that are too deep to evaluate combinationally in the D-stage comparator: population count and highest-set-bit index. Accepts one operation at a time through a start/busy/done handshake and scans STEP bits per cycle. Drives a stall request so the pipeline holds the branch in D until the condition resolves. Fixed latency regardless of operand values, so the hazard logic can treat it like the MDU.

Parameters:
STEP, 4, operand bits processed per RUN cycle; legal values 1, 2, 4, 8; NCHUNK = 32/STEP.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  request; accepted only in IDLE or DONE.
flush  input  1  synchronous abort of an in-flight operation.
mode  input  2  00 CNT_EQ, 01 HIGH_EQ, 10 CNT_GE, 11 reserved.
srcA  input  32  operand A, sampled on accept.
srcB  input  32  operand B, sampled on accept.
busy  output  1  high in RUN.
stall  output  1  combinational: busy | (start & accept_ok).
done  output  1  high for exactly the DONE state.
cond  output  1  branch condition, valid while done=1.
result  output  6  count or index, valid while done=1.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, cond, result, chunk counter, internal accumulators all 0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> latch srcA, srcB, mode; clear accumulators, chunk=0, result=0, cond=0; next state RUN.
- RUN: each cycle process bits [STEP*chunk+STEP-1 : STEP*chunk] of the latched operands; chunk increments. After chunk NCHUNK-1 is processed, next state DONE. start is ignored in RUN.
- DONE: done=1, busy=0. result and cond hold. start=1 here is accepted exactly as in IDLE, giving back-to-back operations with one DONE cycle between them. Without start, stay in DONE. result and cond hold until the next accept.
- Latency: accept at edge t; RUN occupies cycles t+1..t+NCHUNK; done=1 from cycle t+NCHUNK+1. With STEP=4, done asserts 9 cycles after the accept edge.
- CNT_EQ: result = popcount(A) (0..32); cond = (result == srcB[5:0]).
- HIGH_EQ: scan low to high; on each set bit, record its index as highest. result = highest index, or 6'd63 if A==0; cond = (result == srcB[5:0]). The A==0 case must terminate normally, with no hang.
- CNT_GE: popcount of A and B accumulated in parallel; result = popcount(A); cond = (popcount(A) >= popcount(B)), unsigned.
- mode 11: full latency; result=0, cond=0.
- Accumulators are 6-bit unsigned; 32 cannot overflow.
- flush=1: in RUN -> IDLE next edge, no done pulse, result=0, cond=0. In DONE -> IDLE, done drops. flush has priority over start in the same cycle.
- reset asserted mid-RUN: immediate return to reset values; the operation is lost.
- stall: high in the accept cycle and throughout RUN; low in DONE, so the branch resolves in that cycle.

Test Plan:
- CNT_EQ, STEP=4: A=0xF0F0_0001, B=9 -> busy for 8 cycles, done at t+9, result=9, cond=1; same with B=8 -> cond=0.
- HIGH_EQ: A=0x0004_0010, B=18 -> result=18, cond=1. A=0, B=0 -> result=63, cond=0, done still at t+9.
- CNT_GE: A=0x0000_00FF, B=0xFFFF_0000 -> result=8, cond=0. Swapped operands -> result=16, cond=1.
- Handshake: start pulsed in RUN cycles 3 and 5 -> ignored, single done. start held in the DONE cycle -> new op accepted, done low next cycle, second done 9 cycles later; stall=1 only in the accept cycle and RUN.
- flush in RUN cycle 4 -> IDLE next edge, busy=0, no done, result=0. flush+start in the same DONE cycle -> IDLE.
- reset low mid-RUN, asynchronous to clk -> all outputs 0 immediately. Rerun CNT_EQ with STEP=1 (done at t+33) and STEP=8 (done at t+5) -> same result values.
